noc_pe_burst_gen: RTL and testbench

//  Parametrised NoC processing element. It generates counted bursts of flits toward a selectable destination node.
//  It arbitrates with the master via a req/grant handshake and honours router backpressure (tx_ready).
//  It also monitors the inbound flit stream from its router. Sits between the testbench/user stimulus and one router port.

---
 rtl/noc_pkg.sv | 19 +
 rtl/noc_pe_burst_gen_if.sv | 36 +++
 rtl/noc_pe_rx_monitor.sv | 83 ++++++++
 rtl/noc_pe_burst_gen.sv | 121 ++++++++++++
 tb/tb_noc_pe_burst_gen.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared types and default sizing for the NoC processing element slice.
package noc_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_NUM_NODES = 4;
    localparam int unsigned DEF_LEN_W     = 8;

    typedef struct packed {
        logic                  last;
        logic [DEF_DATA_W-1:0] payload;
    } flit_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SEND
    } pe_state_e;

endpackage

// File: rtl/noc_pe_burst_gen_if.sv
// Handshake/bus bundle between user stimulus, master arbiter, router port and the PE.
interface noc_pe_burst_gen_if #(
    parameter int unsigned DATA_W    = noc_pkg::DEF_DATA_W,
    parameter int unsigned NUM_NODES = noc_pkg::DEF_NUM_NODES,
    parameter int unsigned LEN_W     = noc_pkg::DEF_LEN_W
);
    localparam int unsigned DEST_W = $clog2(NUM_NODES);

    logic              tb_request;
    logic [DEST_W-1:0] tb_dest;
    logic [LEN_W-1:0]  tb_len;
    logic              grant;
    logic              tx_ready;
    logic [DATA_W:0]   rx_flit;
    logic              rx_valid;

    logic              req;
    logic [DEST_W-1:0] dest;
    logic [DATA_W:0]   tx_flit;
    logic              tx_valid;
    logic              pe_ready;
    logic [LEN_W-1:0]  rx_count;
    logic              rx_done;
    logic              rx_err;

    modport slave (
        input  tb_request, tb_dest, tb_len, grant, tx_ready, rx_flit, rx_valid,
        output req, dest, tx_flit, tx_valid, pe_ready, rx_count, rx_done, rx_err
    );

    modport master (
        output tb_request, tb_dest, tb_len, grant, tx_ready, rx_flit, rx_valid,
        input  req, dest, tx_flit, tx_valid, pe_ready, rx_count, rx_done, rx_err
    );

endinterface

// File: rtl/noc_pe_rx_monitor.sv
// Inbound flit counter with completion pulse; optional payload sequence checker
// enabled by NOC_PE_RX_SEQ_CHECK_EN.
module noc_pe_rx_monitor #(
    parameter int unsigned DATA_W = noc_pkg::DEF_DATA_W,
    parameter int unsigned LEN_W  = noc_pkg::DEF_LEN_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DATA_W:0]  rx_flit_i,
    input  logic             rx_valid_i,
    output logic [LEN_W-1:0] rx_count_o,
    output logic             rx_done_o,
    output logic             rx_err_o
);

    logic [LEN_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [LEN_W-1:0] rx_count_q, rx_count_d;
    logic             rx_done_q, rx_done_d;
    logic [LEN_W-1:0] rx_cnt_inc;
    logic             rx_last;

    assign rx_last    = rx_flit_i[DATA_W];
    // Saturating position of the flit currently on the input (1-based).
    assign rx_cnt_inc = (rx_cnt_q == '1) ? rx_cnt_q : rx_cnt_q + LEN_W'(1);

    always_comb begin
        rx_cnt_d   = rx_cnt_q;
        rx_count_d = rx_count_q;
        rx_done_d  = 1'b0;
        if (rx_valid_i) begin
            if (rx_last) begin
                rx_count_d = rx_cnt_inc;
                rx_done_d  = 1'b1;
                rx_cnt_d   = '0;
            end else begin
                rx_cnt_d   = rx_cnt_inc;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_cnt_q   <= '0;
            rx_count_q <= '0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_cnt_q   <= rx_cnt_d;
            rx_count_q <= rx_count_d;
            rx_done_q  <= rx_done_d;
        end
    end

    assign rx_count_o = rx_count_q;
    assign rx_done_o  = rx_done_q;

`ifdef NOC_PE_RX_SEQ_CHECK_EN
    logic rx_err_q, rx_err_d;

    // Sticky: any payload out of position latches the error until reset.
    always_comb begin
        rx_err_d = rx_err_q;
        if (rx_valid_i && (rx_flit_i[DATA_W-1:0] != DATA_W'(rx_cnt_inc))) begin
            rx_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_err_q <= 1'b0;
        end else begin
            rx_err_q <= rx_err_d;
        end
    end

    assign rx_err_o = rx_err_q;
`else
    // Payload is only inspected by the sequence checker.
    logic unused_rx_payload;
    assign unused_rx_payload = ^rx_flit_i[DATA_W-1:0];
    assign rx_err_o          = 1'b0;
`endif

endmodule

// File: rtl/noc_pe_burst_gen.sv
// NoC processing element: requests the master, then emits a counted flit burst
// under router backpressure; inbound stream handled by noc_pe_rx_monitor
// (sequence checking optional via NOC_PE_RX_SEQ_CHECK_EN).
module noc_pe_burst_gen
    import noc_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned NUM_NODES = DEF_NUM_NODES,
    parameter int unsigned LEN_W     = DEF_LEN_W
) (
    input  logic               clock,
    input  logic               reset,
    noc_pe_burst_gen_if.slave  bus
);

    localparam int unsigned DEST_W = $clog2(NUM_NODES);
    localparam int unsigned FLIT_W = DATA_W + 1;

    pe_state_e         state_q, state_d;
    logic              req_q, req_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [FLIT_W-1:0] tx_flit_q, tx_flit_d;
    logic              tx_valid_q, tx_valid_d;
    logic              pe_ready_q, pe_ready_d;
    logic [LEN_W-1:0]  cnt_nxt;

    assign cnt_nxt = cnt_q + LEN_W'(1);

    // Next-state and registered-output logic for the TX burst FSM.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        dest_d     = dest_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        tx_flit_d  = tx_flit_q;
        tx_valid_d = tx_valid_q;
        pe_ready_d = pe_ready_q;

        unique case (state_q)
            IDLE: begin
                if (bus.tb_request && (bus.tb_len != '0)) begin
                    state_d    = REQ;
                    req_d      = 1'b1;
                    pe_ready_d = 1'b0;
                    dest_d     = bus.tb_dest;
                    len_d      = bus.tb_len;
                end
            end
            REQ: begin
                if (bus.grant) begin
                    state_d    = SEND;
                    req_d      = 1'b0;
                    cnt_d      = LEN_W'(1);
                    tx_valid_d = 1'b1;
                    tx_flit_d  = {len_q == LEN_W'(1), DATA_W'(1)};
                end
            end
            SEND: begin
                if (bus.tx_ready) begin
                    if (cnt_q == len_q) begin
                        state_d    = IDLE;
                        tx_valid_d = 1'b0;
                        tx_flit_d  = '0;
                        pe_ready_d = 1'b1;
                    end else begin
                        cnt_d      = cnt_nxt;
                        tx_flit_d  = {cnt_nxt == len_q, DATA_W'(cnt_nxt)};
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            dest_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            tx_flit_q  <= '0;
            tx_valid_q <= 1'b0;
            pe_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            dest_q     <= dest_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            tx_flit_q  <= tx_flit_d;
            tx_valid_q <= tx_valid_d;
            pe_ready_q <= pe_ready_d;
        end
    end

    assign bus.req      = req_q;
    assign bus.dest     = dest_q;
    assign bus.tx_flit  = tx_flit_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.pe_ready = pe_ready_q;

    noc_pe_rx_monitor #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_rx_monitor (
        .clock      (clock),
        .reset      (reset),
        .rx_flit_i  (bus.rx_flit),
        .rx_valid_i (bus.rx_valid),
        .rx_count_o (bus.rx_count),
        .rx_done_o  (bus.rx_done),
        .rx_err_o   (bus.rx_err)
    );

endmodule

// File: tb/tb_noc_pe_burst_gen.sv
// Scoreboard bench for noc_pe_burst_gen: TX bursts, backpressure, reset abort,
// RX counting and (with NOC_PE_RX_SEQ_CHECK_EN) the sequence checker.
module tb_noc_pe_burst_gen;
    import noc_pkg::*;

    localparam int unsigned DATA_W    = DEF_DATA_W;
    localparam int unsigned NUM_NODES = DEF_NUM_NODES;
    localparam int unsigned LEN_W     = DEF_LEN_W;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    noc_pe_burst_gen_if #(.DATA_W(DATA_W), .NUM_NODES(NUM_NODES), .LEN_W(LEN_W)) bus ();

    noc_pe_burst_gen #(.DATA_W(DATA_W), .NUM_NODES(NUM_NODES), .LEN_W(LEN_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    flit_t       tx_q[$];
    int unsigned rx_q[$];
    logic        stalled  = 1'b0;
    logic [DATA_W:0] held_flit = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_burst(input int unsigned len);
        flit_t f;
        for (int unsigned i = 1; i <= len; i++) begin
            f.last    = (i == len);
            f.payload = DATA_W'(i);
            tx_q.push_back(f);
        end
    endtask

    task automatic wait_idle(input int max_cycles, input string tag);
        int n = 0;
        while (!bus.pe_ready && n < max_cycles) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(bus.pe_ready), 32'd1);
    endtask

    // Request a burst, grant it after grant_delay cycles; returns with flit 1 on the bus.
    task automatic start_burst(input int unsigned dst, input int unsigned len, input int grant_delay);
        bus.tb_request = 1'b1;
        bus.tb_dest    = 2'(dst);
        bus.tb_len     = LEN_W'(len);
        tick();
        bus.tb_request = 1'b0;
        check_eq("req_raised", 32'(bus.req), 32'd1);
        check_eq("dest_latched", 32'(bus.dest), 32'(dst));
        check_eq("busy_in_req", 32'(bus.pe_ready), 32'd0);
        repeat (grant_delay) tick();
        expect_burst(len);
        bus.grant = 1'b1;
        tick();
        bus.grant = 1'b0;
        check_eq("req_dropped", 32'(bus.req), 32'd0);
    endtask

    task automatic drive_rx(input logic [DATA_W:0] f);
        bus.rx_flit  = f;
        bus.rx_valid = 1'b1;
        tick();
    endtask

    // Output monitor: scoreboard compare on every TX handshake and RX completion.
    always @(negedge clock) begin
        flit_t       e;
        int unsigned ec;
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) check_eq("tx_hold", 32'(bus.tx_flit), 32'(held_flit));
            stalled   = bus.tx_valid && !bus.tx_ready;
            held_flit = bus.tx_flit;
            if (bus.tx_valid && bus.tx_ready) begin
                if (tx_q.size() == 0) begin
                    check_eq("tx_unexpected", 32'(bus.tx_valid), 32'd0);
                end else begin
                    e = tx_q.pop_front();
                    check_eq("tx_flit", 32'(bus.tx_flit), 32'(e));
                end
            end
            if (bus.rx_done) begin
                if (rx_q.size() == 0) begin
                    check_eq("rx_unexpected", 32'(bus.rx_done), 32'd0);
                end else begin
                    ec = rx_q.pop_front();
                    check_eq("rx_count", 32'(bus.rx_count), ec);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.tb_request = 1'b0;
        bus.tb_dest    = '0;
        bus.tb_len     = '0;
        bus.grant      = 1'b0;
        bus.tx_ready   = 1'b1;
        bus.rx_flit    = '0;
        bus.rx_valid   = 1'b0;

        tick();
        tick();
        check_eq("rst_req", 32'(bus.req), 32'd0);
        check_eq("rst_dest", 32'(bus.dest), 32'd0);
        check_eq("rst_tx_flit", 32'(bus.tx_flit), 32'd0);
        check_eq("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check_eq("rst_pe_ready", 32'(bus.pe_ready), 32'd1);
        check_eq("rst_rx_count", 32'(bus.rx_count), 32'd0);
        check_eq("rst_rx_done", 32'(bus.rx_done), 32'd0);
        check_eq("rst_rx_err", 32'(bus.rx_err), 32'd0);
        reset = 1'b0;
        tick();

        // 1: dest=2 len=3, grant two cycles after req, consecutive flits.
        start_burst(2, 3, 2);
        check_eq("t1_valid", 32'(bus.tx_valid), 32'd1);
        tick();
        tick();
        tick();
        check_eq("t1_done_ready", 32'(bus.pe_ready), 32'd1);
        check_eq("t1_done_valid", 32'(bus.tx_valid), 32'd0);
        check_eq("t1_queue_empty", 32'(tx_q.size()), 32'd0);

        // 2: len=4 with backpressure on SEND cycles 2-3.
        start_burst(1, 4, 1);
        tick();
        bus.tx_ready = 1'b0;
        tick();
        check_eq("t2_stall_flit", 32'(bus.tx_flit), 32'h002);
        tick();
        bus.tx_ready = 1'b1;
        wait_idle(20, "t2_idle");
        check_eq("t2_queue_empty", 32'(tx_q.size()), 32'd0);

        // 3: zero length request is ignored.
        bus.tb_request = 1'b1;
        bus.tb_len     = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t3_no_req", 32'(bus.req), 32'd0);
            check_eq("t3_ready", 32'(bus.pe_ready), 32'd1);
        end
        bus.tb_request = 1'b0;

        // 4: reset during flit 2 of a len=5 burst, then a fresh burst.
        start_burst(3, 5, 0);
        tick();
        reset = 1'b1;
        #1;
        check_eq("t4_abort_valid", 32'(bus.tx_valid), 32'd0);
        check_eq("t4_abort_ready", 32'(bus.pe_ready), 32'd1);
        check_eq("t4_abort_dest", 32'(bus.dest), 32'd0);
        tx_q.delete();
        tick();
        reset = 1'b0;
        tick();
        start_burst(1, 2, 0);
        check_eq("t4_restart_flit", 32'(bus.tx_flit), 32'h001);
        wait_idle(20, "t4_idle");
        check_eq("t4_queue_empty", 32'(tx_q.size()), 32'd0);

        // Max length burst: payload runs 1..255, last only on 0x1FF.
        start_burst(3, 255, 1);
        wait_idle(300, "tmax_idle");
        check_eq("tmax_queue_empty", 32'(tx_q.size()), 32'd0);

        // 5: clean inbound packet of three flits.
        rx_q.push_back(3);
        drive_rx(9'h001);
        drive_rx(9'h002);
        drive_rx(9'h103);
        bus.rx_valid = 1'b0;
        check_eq("t5_done", 32'(bus.rx_done), 32'd1);
        check_eq("t5_count", 32'(bus.rx_count), 32'd3);
        check_eq("t5_err", 32'(bus.rx_err), 32'd0);
        tick();
        check_eq("t5_done_pulse", 32'(bus.rx_done), 32'd0);

        // 6: out-of-sequence inbound packet.
        rx_q.push_back(3);
        drive_rx(9'h001);
        check_eq("t6_err_first", 32'(bus.rx_err), 32'd0);
        drive_rx(9'h003);
`ifdef NOC_PE_RX_SEQ_CHECK_EN
        check_eq("t6_err_set", 32'(bus.rx_err), 32'd1);
`else
        check_eq("t6_err_tied", 32'(bus.rx_err), 32'd0);
`endif
        drive_rx(9'h104);
        bus.rx_valid = 1'b0;
        tick();
        rx_q.push_back(2);
        drive_rx(9'h001);
        drive_rx(9'h102);
        bus.rx_valid = 1'b0;
        tick();
`ifdef NOC_PE_RX_SEQ_CHECK_EN
        check_eq("t6_err_sticky", 32'(bus.rx_err), 32'd1);
`else
        check_eq("t6_err_still_tied", 32'(bus.rx_err), 32'd0);
`endif
        reset = 1'b1;
        tick();
        check_eq("t6_err_cleared", 32'(bus.rx_err), 32'd0);
        reset = 1'b0;
        tick();

        check_eq("end_tx_queue", 32'(tx_q.size()), 32'd0);
        check_eq("end_rx_queue", 32'(rx_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
